// File: rtl/tx_ring_controller.sv
// Ring-buffer transmit sequencer: fills NUM_BUF word buffers, shifts them out bit by bit.
// Optional word-count limit (tx_len/tx_done) enabled with `define TXC_BYTE_LIMIT_EN.
module tx_ring_controller #(
  parameter int DATA_W  = 8,
  parameter int NUM_BUF = 2,
  parameter int PTR_W   = $clog2(NUM_BUF),
  parameter int CNT_W   = $clog2(DATA_W + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cstx,
  input  logic               src_valid,
  output logic               src_ready,
  input  logic               bit_tick,
  input  logic               ack_valid,
  input  logic               data_ack,
`ifdef TXC_BYTE_LIMIT_EN
  input  logic [15:0]        tx_len,
  output logic               tx_done,
`endif
  output logic [NUM_BUF-1:0] load_buf,
  output logic [NUM_BUF-1:0] shift_buf,
  output logic [PTR_W-1:0]   sel_buf,
  output logic [CNT_W-1:0]   bit_cnt,
  output logic               valid_data,
  output logic               byte_done,
  output logic               busy,
  output logic               nack_err
);

  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(NUM_BUF);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRELOAD,
    S_SHIFT,
    S_WAIT,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d, occ_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             nack_q, nack_d;

  logic en, fill_st, load, shift, ack, rel;
  logic lim_ok;

`ifdef TXC_BYTE_LIMIT_EN
  logic [15:0] len_q, len_d;
  logic [15:0] done_q, done_d;
  logic [15:0] acc_q, acc_d;
  logic        tx_done_c;
`endif

  // Strobes are suppressed whenever the transfer is being torn down.
  assign en      = cstx & ~rst;
  assign fill_st = (state_q == S_PRELOAD) |
                   (state_q == S_SHIFT) |
                   (state_q == S_WAIT);

`ifdef TXC_BYTE_LIMIT_EN
  assign lim_ok  = (acc_q != len_q);
  assign tx_done = tx_done_c & en;
`else
  assign lim_ok  = 1'b1;
`endif

  assign src_ready = en & fill_st & (occ_q != OCC_FULL) & lim_ok;
  assign load      = src_valid & src_ready;
  assign shift     = en & (state_q == S_SHIFT) & bit_tick;
  assign ack       = en & (state_q == S_WAIT) & ack_valid;
  assign rel       = ack & data_ack;
  assign occ_nxt   = occ_q + OCC_W'(load) - OCC_W'(rel);

  assign load_buf   = load ? (NUM_BUF'(1) << wr_ptr_q) : '0;
  assign shift_buf  = shift ? (NUM_BUF'(1) << rd_ptr_q) : '0;
  assign sel_buf    = rd_ptr_q;
  assign bit_cnt    = cnt_q;
  assign valid_data = valid_q;
  assign byte_done  = rel;
  assign busy       = (state_q != S_IDLE);
  assign nack_err   = nack_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_nxt;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    nack_d   = nack_q;
`ifdef TXC_BYTE_LIMIT_EN
    len_d     = len_q;
    done_d    = done_q;
    acc_d     = acc_q;
    tx_done_c = 1'b0;
    if (load) acc_d = acc_q + 16'd1;
`endif
    if (load) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rel)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case (state_q)
      S_IDLE: begin
        if (cstx) begin
          state_d = S_PRELOAD;
          nack_d  = 1'b0;
`ifdef TXC_BYTE_LIMIT_EN
          len_d  = tx_len;
          done_d = '0;
          acc_d  = '0;
`endif
        end
      end
      S_PRELOAD: begin
`ifdef TXC_BYTE_LIMIT_EN
        if (len_q == 16'd0) begin
          state_d   = S_STOP;
          tx_done_c = 1'b1;
        end else
`endif
        if (occ_nxt != '0) begin
          state_d = S_SHIFT;
          cnt_d   = CNT_MAX;
          valid_d = 1'b1;
        end
      end
      S_SHIFT: begin
        if (shift) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_WAIT;
            valid_d = 1'b0;
          end
        end
      end
      S_WAIT: begin
        if (ack) begin
          if (data_ack) begin
`ifdef TXC_BYTE_LIMIT_EN
            done_d = done_q + 16'd1;
            if (done_q + 16'd1 == len_q) begin
              state_d   = S_STOP;
              tx_done_c = 1'b1;
            end else
`endif
            if (occ_nxt != '0) begin
              state_d = S_SHIFT;
              cnt_d   = CNT_MAX;
              valid_d = 1'b1;
            end else begin
              state_d = S_PRELOAD;
            end
          end else begin
            state_d = S_STOP;
            nack_d  = 1'b1;
          end
        end
      end
      S_STOP: begin
        state_d = S_STOP;
      end
      default: state_d = S_IDLE;
    endcase

    // Dropping cstx tears the transfer down but keeps the NACK record.
    if (!cstx) begin
      state_d  = S_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      cnt_d    = '0;
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      nack_q   <= 1'b0;
`ifdef TXC_BYTE_LIMIT_EN
      len_q    <= '0;
      done_q   <= '0;
      acc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      nack_q   <= nack_d;
`ifdef TXC_BYTE_LIMIT_EN
      len_q    <= len_d;
      done_q   <= done_d;
      acc_q    <= acc_d;
`endif
    end
  end

endmodule

// File: tb/tb_tx_ring_controller.sv
// Randomized scoreboard bench for tx_ring_controller in two configurations:
// (DATA_W=8, NUM_BUF=2) and (DATA_W=12, NUM_BUF=4), sharing one stimulus stream.
module tb_tx_ring_controller;

  typedef struct packed {
    logic       rdy;
    logic [3:0] ld;
    logic [3:0] sh;
    logic [1:0] sel;
    logic [3:0] cnt;
    logic       vld;
    logic       bd;
    logic       bsy;
    logic       nk;
  } obs_t;

  logic clk = 1'b0;
  logic rst, cstx, src_valid, bit_tick, ack_valid, data_ack;

  logic       rdy0, vld0, bd0, bsy0, nk0;
  logic [1:0] ld0, sh0;
  logic [0:0] sel0;
  logic [3:0] cnt0;

  logic       rdy1, vld1, bd1, bsy1, nk1;
  logic [3:0] ld1, sh1;
  logic [1:0] sel1;
  logic [3:0] cnt1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  obs_t q0[$];
  obs_t q1[$];
  obs_t act0, act1;

  // Abstract model: words are counted in/out; slot = count mod NUM_BUF.
  int DW[2] = '{8, 12};
  int NB[2] = '{2, 4};
  bit m_on[2], m_stop[2], m_inword[2], m_nack[2];
  int m_bits[2], m_loaded[2], m_released[2];

  always #5 clk = ~clk;

  tx_ring_controller #(.DATA_W(8), .NUM_BUF(2)) u0 (
    .clk(clk), .rst(rst), .cstx(cstx),
    .src_valid(src_valid), .src_ready(rdy0),
    .bit_tick(bit_tick), .ack_valid(ack_valid), .data_ack(data_ack),
    .load_buf(ld0), .shift_buf(sh0), .sel_buf(sel0), .bit_cnt(cnt0),
    .valid_data(vld0), .byte_done(bd0), .busy(bsy0), .nack_err(nk0)
  );

  tx_ring_controller #(.DATA_W(12), .NUM_BUF(4)) u1 (
    .clk(clk), .rst(rst), .cstx(cstx),
    .src_valid(src_valid), .src_ready(rdy1),
    .bit_tick(bit_tick), .ack_valid(ack_valid), .data_ack(data_ack),
    .load_buf(ld1), .shift_buf(sh1), .sel_buf(sel1), .bit_cnt(cnt1),
    .valid_data(vld1), .byte_done(bd1), .busy(bsy1), .nack_err(nk1)
  );

  assign act0 = '{rdy: rdy0, ld: {2'b00, ld0}, sh: {2'b00, sh0},
                  sel: {1'b0, sel0}, cnt: cnt0, vld: vld0,
                  bd: bd0, bsy: bsy0, nk: nk0};
  assign act1 = '{rdy: rdy1, ld: ld1, sh: sh1, sel: sel1, cnt: cnt1,
                  vld: vld1, bd: bd1, bsy: bsy1, nk: nk1};

  function automatic void model_clear(int i, bit keep_nack);
    m_on[i]       = 0;
    m_stop[i]     = 0;
    m_inword[i]   = 0;
    m_bits[i]     = 0;
    m_loaded[i]   = 0;
    m_released[i] = 0;
    if (!keep_nack) m_nack[i] = 0;
  endfunction

  function automatic obs_t model_step(int i);
    obs_t e;
    bit en, ld, sh, ak;
    int occ;
    en    = cstx && !rst;
    occ   = m_loaded[i] - m_released[i];
    e     = '0;
    e.bsy = m_on[i];
    e.nk  = m_nack[i];
    e.vld = m_inword[i] && m_bits[i] > 0;
    e.cnt = m_inword[i] ? 4'(m_bits[i]) : 4'd0;
    e.sel = 2'(m_released[i] % NB[i]);
    e.rdy = en && m_on[i] && !m_stop[i] && occ < NB[i];
    ld    = src_valid && e.rdy;
    e.ld  = ld ? 4'(1 << (m_loaded[i] % NB[i])) : 4'd0;
    sh    = en && e.vld && bit_tick;
    e.sh  = sh ? 4'(1 << (m_released[i] % NB[i])) : 4'd0;
    ak    = en && m_on[i] && !m_stop[i] && m_inword[i] &&
            m_bits[i] == 0 && ack_valid;
    e.bd  = ak && data_ack;

    if (rst) model_clear(i, 0);
    else if (!cstx) model_clear(i, 1);
    else if (!m_on[i]) begin
      m_on[i]   = 1;
      m_nack[i] = 0;
    end else if (!m_stop[i]) begin
      if (ld) m_loaded[i]++;
      if (!m_inword[i]) begin
        if (m_loaded[i] - m_released[i] >= 1) begin
          m_inword[i] = 1;
          m_bits[i]   = DW[i];
        end
      end else if (m_bits[i] > 0) begin
        if (sh) m_bits[i]--;
      end else if (ak) begin
        if (data_ack) begin
          m_released[i]++;
          if (m_loaded[i] - m_released[i] >= 1) m_bits[i] = DW[i];
          else m_inword[i] = 0;
        end else begin
          m_stop[i]   = 1;
          m_nack[i]   = 1;
          m_inword[i] = 0;
        end
      end
    end
    return e;
  endfunction

  task automatic check(int i, obs_t got, obs_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL dut%0d cycle %0d: got rdy=%b ld=%b sh=%b sel=%0d cnt=%0d vld=%b bd=%b busy=%b nack=%b want rdy=%b ld=%b sh=%b sel=%0d cnt=%0d vld=%b bd=%b busy=%b nack=%b",
               i, cyc, got.rdy, got.ld, got.sh, got.sel, got.cnt, got.vld,
               got.bd, got.bsy, got.nk, exp.rdy, exp.ld, exp.sh, exp.sel,
               exp.cnt, exp.vld, exp.bd, exp.bsy, exp.nk);
    end
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) check(0, act0, q0.pop_front());
    if (q1.size() > 0) check(1, act1, q1.pop_front());
  end

  task automatic issue();
    q0.push_back(model_step(0));
    q1.push_back(model_step(1));
  endtask

  initial begin
    int p_sv, p_ack;
    rst       = 1'b1;
    cstx      = 1'b1;
    src_valid = 1'b1;
    bit_tick  = 1'b0;
    ack_valid = 1'b0;
    data_ack  = 1'b0;
    model_clear(0, 0);
    model_clear(1, 0);
    @(posedge clk);
    #1;
    cyc++;
    issue();
    p_sv  = 50;
    p_ack = 90;
    for (int n = 0; n < 6000; n++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (n % 250 == 0) begin
        p_sv  = 5 + int'($urandom_range(90));
        p_ack = 70 + int'($urandom_range(30));
      end
      rst       = ($urandom_range(499) == 0);
      cstx      = ($urandom_range(79) != 0);
      src_valid = ($urandom_range(99) < p_sv);
      bit_tick  = ($urandom_range(99) < 60);
      ack_valid = ($urandom_range(99) < 30);
      data_ack  = ($urandom_range(99) < p_ack);
      issue();
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d pending want 0/0",
               q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
